// File: rtl/npu_dot_engine.sv
// npu_dot_engine: descriptor-driven int8x4 dot-product engine that reads length, weight
// pointer, bias and operand words over a simple read port and returns a saturated result.
module npu_dot_engine #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] accelerator_cmd,
    input  logic                  accelerator_start,
    output logic                  accelerator_done,
    output logic [DATA_WIDTH-1:0] accelerator_result,
    output logic                  busy,
    output logic                  err,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_re,
    input  logic [DATA_WIDTH-1:0] mem_data_in,
    input  logic                  mem_ready
);
    typedef enum logic [2:0] {IDLE, RD_LEN, RD_WADDR, RD_BIAS, RD_IN, RD_W, MAC, FINISH} state_t;

    state_t                  state;
    logic [7:0]              op;
    logic [23:0]             base;
    logic [15:0]             n;
    logic [15:0]             i;
    logic [ADDR_WIDTH-1:0]   waddr;
    logic [31:0]             bias;
    logic [31:0]             in_word;
    logic [31:0]             w_word;
    logic signed [47:0]      acc;
    logic signed [17:0]      prod [4];
    logic signed [17:0]      lane_sum;
    logic signed [47:0]      acc_nxt;
    logic signed [48:0]      fin_sum;
    logic [31:0]             sat;
    logic [31:0]             fin_res;
    logic [16:0]             i_nxt;
    logic [ADDR_WIDTH-1:0]   b;
    logic [ADDR_WIDTH-1:0]   off;
    logic                    op_ok;

    assign op_ok = accelerator_cmd[31:24] == 8'h01 || accelerator_cmd[31:24] == 8'h02;
    assign i_nxt = {1'b0, i} + 17'd1;
    assign b     = ADDR_WIDTH'(base);
    assign off   = ADDR_WIDTH'({i, 2'b00});

    always_comb begin
        for (int k = 0; k < 4; k++)
            prod[k] = 18'($signed(in_word[8*k +: 8])) * 18'($signed(w_word[8*k +: 8]));
        lane_sum = prod[0] + prod[1] + prod[2] + prod[3];
        acc_nxt  = acc + 48'(lane_sum);
        // The final sum is formed on the edge entering FINISH, so the bias may still be on the bus
        fin_sum  = 49'(state == MAC ? acc_nxt : acc)
                 + 49'($signed(state == RD_BIAS ? mem_data_in : bias));
        sat      = fin_sum > 49'sd2147483647  ? 32'h7FFF_FFFF :
                   fin_sum < -49'sd2147483648 ? 32'h8000_0000 : fin_sum[31:0];
        fin_res  = (op == 8'h02 && sat[31]) ? 32'h0 : sat;
    end

    assign busy   = state != IDLE;
    assign mem_re = state inside {RD_LEN, RD_WADDR, RD_BIAS, RD_IN, RD_W};
    assign mem_addr = state == RD_LEN   ? b :
                      state == RD_WADDR ? b + ADDR_WIDTH'(4) :
                      state == RD_BIAS  ? b + ADDR_WIDTH'(8) :
                      state == RD_IN    ? b + ADDR_WIDTH'(12) + off :
                      state == RD_W     ? waddr + off : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state              <= IDLE;
            op                 <= '0;
            base               <= '0;
            n                  <= '0;
            i                  <= '0;
            waddr              <= '0;
            bias               <= '0;
            in_word            <= '0;
            w_word             <= '0;
            acc                <= '0;
            accelerator_done   <= 1'b0;
            accelerator_result <= '0;
            err                <= 1'b0;
        end else begin
            accelerator_done <= 1'b0;
            case (state)
                IDLE: if (accelerator_start) begin
                    op                 <= accelerator_cmd[31:24];
                    base               <= accelerator_cmd[23:0];
                    acc                <= '0;
                    i                  <= '0;
                    accelerator_result <= '0;
                    err                <= !op_ok;
                    accelerator_done   <= !op_ok;
                    state              <= op_ok ? RD_LEN : FINISH;
                end
                RD_LEN: if (mem_ready) begin
                    n     <= mem_data_in[15:0];
                    state <= RD_WADDR;
                end
                RD_WADDR: if (mem_ready) begin
                    waddr <= ADDR_WIDTH'(mem_data_in);
                    state <= RD_BIAS;
                end
                RD_BIAS: if (mem_ready) begin
                    bias <= mem_data_in;
                    if (n == 16'd0) begin
                        accelerator_result <= fin_res;
                        accelerator_done   <= 1'b1;
                        state              <= FINISH;
                    end else
                        state <= RD_IN;
                end
                RD_IN: if (mem_ready) begin
                    in_word <= mem_data_in;
                    state   <= RD_W;
                end
                RD_W: if (mem_ready) begin
                    w_word <= mem_data_in;
                    state  <= MAC;
                end
                MAC: begin
                    acc <= acc_nxt;
                    i   <= i_nxt[15:0];
                    if (i_nxt < {1'b0, n})
                        state <= RD_IN;
                    else begin
                        accelerator_result <= fin_res;
                        accelerator_done   <= 1'b1;
                        state              <= FINISH;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_npu_dot_engine.sv
// tb_npu_dot_engine: directed scoreboard bench for npu_dot_engine with a word-addressed
// memory model, optional read stalls and a mid-operation reset.
module tb_npu_dot_engine;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] cmd = '0;
    logic        start = 1'b0;
    logic        done;
    logic [31:0] result;
    logic        busy;
    logic        err;
    logic [31:0] mem_addr;
    logic        mem_re;
    logic [31:0] mem_data_in;
    logic        mem_ready;

    logic [31:0] mem [256];
    logic [31:0] in_w [4];
    logic [31:0] wt_w [4];
    int          stall = 0;
    int          wait_cnt = 0;
    int          re_cnt = 0;
    int          unstable = 0;
    logic        was_stalled = 1'b0;
    logic [31:0] stall_addr = '0;
    logic [31:0] rd_log [$];
    int          checks = 0;
    int          errors = 0;

    typedef struct {
        logic [31:0] res;
        logic        err;
        int          cyc;
    } exp_t;
    exp_t sb [$];

    localparam logic [31:0] B = 32'h100;
    localparam logic [31:0] W = 32'h200;

    npu_dot_engine #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .accelerator_cmd(cmd), .accelerator_start(start),
        .accelerator_done(done), .accelerator_result(result), .busy(busy), .err(err),
        .mem_addr(mem_addr), .mem_re(mem_re), .mem_data_in(mem_data_in), .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    assign mem_data_in = mem[mem_addr[9:2]];
    assign mem_ready   = mem_re && (wait_cnt >= stall);

    always @(posedge clk) begin
        wait_cnt <= (!mem_re || mem_ready) ? 0 : wait_cnt + 1;
        if (mem_re) re_cnt <= re_cnt + 1;
        if (mem_re && mem_ready) rd_log.push_back(mem_addr);
        if (was_stalled && mem_re && mem_addr != stall_addr) unstable <= unstable + 1;
        was_stalled <= mem_re && !mem_ready;
        stall_addr  <= mem_addr;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [7:0] op, input int n, input logic [31:0] bias);
        longint acc = 0;
        for (int j = 0; j < n; j++)
            for (int k = 0; k < 4; k++)
                acc += longint'($signed(in_w[j][8*k +: 8])) * longint'($signed(wt_w[j][8*k +: 8]));
        acc += longint'($signed(bias));
        if (acc > 64'sd2147483647) acc = 64'sd2147483647;
        if (acc < -64'sd2147483648) acc = -64'sd2147483648;
        if (op == 8'h02 && acc < 0) acc = 0;
        return acc[31:0];
    endfunction

    task automatic load(input int n, input logic [31:0] bias);
        mem[B[9:2]]     = 32'(n);
        mem[B[9:2] + 1] = W;
        mem[B[9:2] + 2] = bias;
        for (int j = 0; j < n; j++) begin
            mem[B[9:2] + 3 + j] = in_w[j];
            mem[W[9:2] + j]     = wt_w[j];
        end
    endtask

    task automatic kick(input logic [7:0] op);
        @(negedge clk);
        cmd   = {op, B[23:0]};
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run(input logic [7:0] op, input int n, input logic [31:0] bias,
                       input logic inject, input string tag);
        exp_t e;
        int   cyc;
        logic ok = op == 8'h01 || op == 8'h02;
        load(n, bias);
        sb.push_back('{res: ok ? model(op, n, bias) : 32'h0, err: !ok,
                       cyc: ok ? 4 + 3*n + stall*(3 + 2*n) : 1});
        kick(op);
        cyc = 1;
        while (!done && cyc < 400) begin
            @(negedge clk);
            cyc++;
            start = inject && cyc == 2;
            if (start) cmd = {8'h07, B[23:0]};
        end
        start = 1'b0;
        e = sb.pop_front();
        check({tag, " done"}, 64'(done), 64'(1));
        check({tag, " result"}, 64'(result), 64'(e.res));
        check({tag, " err"}, 64'(err), 64'(e.err));
        check({tag, " latency"}, 64'(cyc), 64'(e.cyc));
        @(negedge clk);
        check({tag, " single pulse"}, 64'(done), 64'(0));
        check({tag, " result held"}, 64'(result), 64'(e.res));
    endtask

    initial begin
        int rd0, re0, late;
        foreach (mem[j]) mem[j] = '0;
        repeat (3) @(negedge clk);
        check("reset done", 64'(done), 64'(0));
        check("reset result", 64'(result), 64'(0));
        check("reset err", 64'(err), 64'(0));
        check("reset busy", 64'(busy), 64'(0));
        check("reset mem_re", 64'(mem_re), 64'(0));
        check("reset mem_addr", 64'(mem_addr), 64'(0));
        rst_n = 1'b1;

        in_w[0] = 32'h01020304; wt_w[0] = 32'h01010101;
        run(8'h01, 1, 32'd5, 1'b0, "dot n1");
        check("dot n1 value", 64'(result), 64'(15));

        in_w[0] = 32'h80808080; in_w[1] = 32'h80808080;
        wt_w[0] = 32'h7F7F7F7F; wt_w[1] = 32'h7F7F7F7F;
        run(8'h02, 2, 32'd0, 1'b0, "relu clamp");
        run(8'h01, 2, 32'd0, 1'b0, "negative raw");

        rd0 = rd_log.size();
        run(8'h01, 0, 32'hFFFF_FFF6, 1'b0, "n0 bias");
        check("n0 value", 64'(result), 64'(32'hFFFF_FFF6));
        check("n0 read count", 64'(rd_log.size() - rd0), 64'(3));
        check("n0 addr0", 64'(rd_log[rd0]), 64'(B));
        check("n0 addr1", 64'(rd_log[rd0 + 1]), 64'(B + 4));
        check("n0 addr2", 64'(rd_log[rd0 + 2]), 64'(B + 8));

        re0 = re_cnt;
        run(8'h07, 0, 32'd0, 1'b0, "bad opcode");
        check("bad opcode no read", 64'(re_cnt - re0), 64'(0));

        in_w[0] = 32'h05FB7F80; wt_w[0] = 32'h03FD7F7F;
        in_w[1] = 32'h11223344; wt_w[1] = 32'hF0E0D0C0;
        run(8'h01, 2, 32'd100, 1'b1, "busy start ignored");

        in_w[0] = 32'h7F7F7F7F; wt_w[0] = 32'h7F7F7F7F;
        run(8'h01, 1, 32'h7FFF_FFF0, 1'b0, "sat positive");
        in_w[0] = 32'h80808080; wt_w[0] = 32'h7F7F7F7F;
        run(8'h01, 1, 32'h8000_0010, 1'b0, "sat negative");

        stall = 3;
        in_w[0] = 32'h01020304; wt_w[0] = 32'h01010101;
        run(8'h01, 1, 32'd5, 1'b0, "stalled");
        check("stalled addr stable", 64'(unstable), 64'(0));
        stall = 0;

        load(1, 32'd5);
        kick(8'h01);
        repeat (4) @(negedge clk);
        check("in RD_W", 64'({mem_re, mem_addr}), 64'({1'b1, W}));
        rst_n = 1'b0;
        @(negedge clk);
        check("abort done", 64'(done), 64'(0));
        check("abort result", 64'(result), 64'(0));
        check("abort err", 64'(err), 64'(0));
        check("abort busy", 64'(busy), 64'(0));
        check("abort mem", 64'({mem_re, mem_addr}), 64'(0));
        rst_n = 1'b1;
        late = 0;
        repeat (12) begin
            @(negedge clk);
            if (done || busy) late++;
        end
        check("no done after abort", 64'(late), 64'(0));
        run(8'h01, 1, 32'd5, 1'b0, "after abort");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
